// File: rtl/tlc_phase_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_phase_arbiter_pkg
// Description : Shared definitions for the intersection phase arbiter:
//               lamp encodings, pedestrian lamp encodings, phase codes,
//               grant identifiers and the default one-second-based
//               durations for a 50 MHz clock.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_phase_arbiter_pkg;

    // Vehicle lamp encodings
    localparam logic [1:0] c_light_green  = 2'b11;
    localparam logic [1:0] c_light_yellow = 2'b10;
    localparam logic [1:0] c_light_red    = 2'b01;

    // Pedestrian lamp encodings
    localparam logic [1:0] c_walk_dont    = 2'b00;
    localparam logic [1:0] c_walk_walk    = 2'b01;
    localparam logic [1:0] c_walk_flash   = 2'b10;

    // Default durations in clock cycles
    localparam int unsigned c_one_sec       = 32'd50_000_000;
    localparam int unsigned c_allred_def    = c_one_sec;
    localparam int unsigned c_yellow_def    = 3 * c_one_sec;
    localparam int unsigned c_hwy_min_def   = 30 * c_one_sec;
    localparam int unsigned c_farm_min_def  = 3 * c_one_sec;
    localparam int unsigned c_farm_max_def  = 15 * c_one_sec;
    localparam int unsigned c_walk_def      = 10 * c_one_sec;
    localparam int unsigned c_clear_def     = 5 * c_one_sec;

    // Phase codes; codes 8..15 are illegal and recover through ALLRED_B
    typedef enum logic [3:0] {
        ST_HWY_GREEN   = 4'd0,
        ST_HWY_YELLOW  = 4'd1,
        ST_ALLRED_A    = 4'd2,
        ST_FARM_GREEN  = 4'd3,
        ST_FARM_YELLOW = 4'd4,
        ST_WALK        = 4'd5,
        ST_WALK_CLEAR  = 4'd6,
        ST_ALLRED_B    = 4'd7
    } phase_t;

    typedef enum logic {
        GRANT_FARM = 1'b0,
        GRANT_WALK = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/tlc_phase_arbiter_timer.sv
`default_nettype none
// ============================================================================
// Module      : tlc_phase_timer
// Description : Phase dwell counter. Clears to zero on reset or when the
//               arbiter is about to change phase, otherwise counts up and
//               holds at all-ones.
// Ports       : Clk   - clock
//               Rst   - synchronous active-high reset
//               clear - restart counting from zero at the next edge
//               cnt   - cycles spent in the current phase minus one
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_phase_timer #(
    parameter int CNT_W = 31
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlc_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlc_phase_arbiter
// Description : Right-of-way arbiter for the highway / farm road / pedestrian
//               intersection. Highway green is the resting phase; farm and
//               walk requests are served through yellow and all-red
//               clearance phases, alternating on a tie.
// Ports       : Clk           - clock
//               Rst           - synchronous active-high reset
//               farmSensor    - farm vehicle present (level, not latched)
//               walkButton    - pedestrian request (level or pulse)
//               highwaySignal - 11 green, 10 yellow, 01 red
//               farmSignal    - 11 green, 10 yellow, 01 red
//               walkSignal    - 00 DON'T WALK, 01 WALK, 10 flashing
//               walkPending   - latched pedestrian request
//               state         - current phase code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_phase_arbiter
    import tlc_phase_arbiter_pkg::*;
#(
    parameter int unsigned ALLRED_T   = c_allred_def,
    parameter int unsigned YELLOW_T   = c_yellow_def,
    parameter int unsigned HWY_MIN_T  = c_hwy_min_def,
    parameter int unsigned FARM_MIN_T = c_farm_min_def,
    parameter int unsigned FARM_MAX_T = c_farm_max_def,
    parameter int unsigned WALK_T     = c_walk_def,
    parameter int unsigned CLEAR_T    = c_clear_def,
    parameter int          CNT_W      = 31
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       farmSensor,
    input  logic       walkButton,
    output logic [1:0] highwaySignal,
    output logic [1:0] farmSignal,
    output logic [1:0] walkSignal,
    output logic       walkPending,
    output logic [3:0] state
);

    // Terminal counts: cnt == T-1 means T cycles have been spent in a phase
    localparam logic [CNT_W-1:0] c_allred_last   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_yellow_last   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_hwy_min_last  = CNT_W'(HWY_MIN_T - 1);
    localparam logic [CNT_W-1:0] c_farm_min_last = CNT_W'(FARM_MIN_T - 1);
    localparam logic [CNT_W-1:0] c_farm_max_last = CNT_W'(FARM_MAX_T - 1);
    localparam logic [CNT_W-1:0] c_walk_last     = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] c_clear_last    = CNT_W'(CLEAR_T - 1);

    phase_t           r_state;
    phase_t           w_next;
    grant_t           r_grant;
    grant_t           r_last_grant;
    grant_t           w_grant_sel;
    logic             r_walk_pending;
    logic             w_capture;
    logic             w_enter_walk;
    logic [CNT_W-1:0] w_cnt;

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clk   (Clk),
        .Rst   (Rst),
        .clear (w_next != r_state),
        .cnt   (w_cnt)
    );

    // Winner if a grant were captured this cycle; on a tie the requester
    // not served last wins.
    always_comb begin
        w_grant_sel = GRANT_WALK;
        if (farmSensor && r_walk_pending) begin
            w_grant_sel = (r_last_grant == GRANT_WALK) ? GRANT_FARM : GRANT_WALK;
        end else if (farmSensor) begin
            w_grant_sel = GRANT_FARM;
        end
    end

    // Next-state and lamp decode
    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        highwaySignal = c_light_red;
        farmSignal    = c_light_red;
        walkSignal    = c_walk_dont;
        case (r_state)
            ST_HWY_GREEN: begin
                highwaySignal = c_light_green;
                if ((w_cnt >= c_hwy_min_last) && (farmSensor || r_walk_pending)) begin
                    w_next    = ST_HWY_YELLOW;
                    w_capture = 1'b1;
                end
            end
            ST_HWY_YELLOW: begin
                highwaySignal = c_light_yellow;
                if (w_cnt == c_yellow_last) w_next = ST_ALLRED_A;
            end
            ST_ALLRED_A: begin
                if (w_cnt == c_allred_last) begin
                    w_next = (r_grant == GRANT_WALK) ? ST_WALK : ST_FARM_GREEN;
                end
            end
            ST_FARM_GREEN: begin
                farmSignal = c_light_green;
                if (((w_cnt >= c_farm_min_last) && !farmSensor) || (w_cnt == c_farm_max_last)) begin
                    w_next = ST_FARM_YELLOW;
                end
            end
            ST_FARM_YELLOW: begin
                farmSignal = c_light_yellow;
                if (w_cnt == c_yellow_last) w_next = ST_ALLRED_B;
            end
            ST_WALK: begin
                walkSignal = c_walk_walk;
                if (w_cnt == c_walk_last) w_next = ST_WALK_CLEAR;
            end
            ST_WALK_CLEAR: begin
                walkSignal = c_walk_flash;
                if (w_cnt == c_clear_last) w_next = ST_ALLRED_B;
            end
            ST_ALLRED_B: begin
                if (w_cnt == c_allred_last) w_next = ST_HWY_GREEN;
            end
            default: begin
                // Illegal code: all lamps stay red, recover via all-red
                w_next = ST_ALLRED_B;
            end
        endcase
    end

    // A press on the very cycle WALK is entered is absorbed by that WALK
    assign w_enter_walk = (w_next == ST_WALK) && (r_state != ST_WALK);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= ST_ALLRED_B;
            r_grant        <= GRANT_FARM;
            r_last_grant   <= GRANT_WALK;
            r_walk_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_grant      <= w_grant_sel;
                r_last_grant <= w_grant_sel;
            end
            r_walk_pending <= w_enter_walk ? 1'b0 : (r_walk_pending | walkButton);
        end
    end

    assign walkPending = r_walk_pending;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlc_phase_arbiter
// Description : Self-checking bench for tlc_phase_arbiter with short phase
//               durations. A behavioural model predicts the outputs after
//               every clock edge into a scoreboard queue; phase milestones
//               are also checked against hand-derived cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_phase_arbiter;

    localparam int ALLRED_T   = 1;
    localparam int YELLOW_T   = 3;
    localparam int HWY_MIN_T  = 30;
    localparam int FARM_MIN_T = 3;
    localparam int FARM_MAX_T = 15;
    localparam int WALK_T     = 10;
    localparam int CLEAR_T    = 5;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       farmSensor;
    logic       walkButton;
    logic [1:0] highwaySignal;
    logic [1:0] farmSignal;
    logic [1:0] walkSignal;
    logic       walkPending;
    logic [3:0] state;

    always #5 Clk = ~Clk;

    tlc_phase_arbiter #(
        .ALLRED_T   (ALLRED_T),
        .YELLOW_T   (YELLOW_T),
        .HWY_MIN_T  (HWY_MIN_T),
        .FARM_MIN_T (FARM_MIN_T),
        .FARM_MAX_T (FARM_MAX_T),
        .WALK_T     (WALK_T),
        .CLEAR_T    (CLEAR_T),
        .CNT_W      (31)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .farmSensor    (farmSensor),
        .walkButton    (walkButton),
        .highwaySignal (highwaySignal),
        .farmSignal    (farmSignal),
        .walkSignal    (walkSignal),
        .walkPending   (walkPending),
        .state         (state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts cycles already spent in the phase, including the current one
    int m_state;
    int m_age;
    bit m_pend;
    bit m_grant_walk;
    bit m_last_walk;

    task automatic model_edge(input bit rst, input bit farm, input bit btn);
        int nxt;
        bit gw;
        if (rst) begin
            m_state     = 7;
            m_age       = 1;
            m_pend      = 1'b0;
            m_last_walk = 1'b1;
            return;
        end
        nxt = m_state;
        gw  = m_grant_walk;
        case (m_state)
            0: if (m_age >= HWY_MIN_T && (farm || m_pend)) begin
                   nxt = 1;
                   if (farm && m_pend) gw = !m_last_walk;
                   else                gw = !farm;
                   m_last_walk = gw;
               end
            1: if (m_age == YELLOW_T) nxt = 2;
            2: if (m_age == ALLRED_T) nxt = m_grant_walk ? 5 : 3;
            3: if ((m_age >= FARM_MIN_T && !farm) || m_age == FARM_MAX_T) nxt = 4;
            4: if (m_age == YELLOW_T) nxt = 7;
            5: if (m_age == WALK_T) nxt = 6;
            6: if (m_age == CLEAR_T) nxt = 7;
            7: if (m_age == ALLRED_T) nxt = 0;
            default: nxt = 7;
        endcase
        m_pend       = (nxt == 5 && m_state != 5) ? 1'b0 : (m_pend | btn);
        m_age        = (nxt != m_state) ? 1 : m_age + 1;
        m_state      = nxt;
        m_grant_walk = gw;
    endtask

    function automatic logic [10:0] expected_vec(input int s, input bit p);
        logic [1:0] hw;
        logic [1:0] fm;
        logic [1:0] wk;
        hw = (s == 0) ? 2'b11 : (s == 1) ? 2'b10 : 2'b01;
        fm = (s == 3) ? 2'b11 : (s == 4) ? 2'b10 : 2'b01;
        wk = (s == 5) ? 2'b01 : (s == 6) ? 2'b10 : 2'b00;
        return {4'(s), hw, fm, wk, p};
    endfunction

    // ---------------- scoreboard ----------------
    logic [10:0] sb_q[$];

    task automatic cycle(input bit rst, input bit farm, input bit btn);
        logic [10:0] got;
        logic [10:0] exp;
        logic        conflict;
        @(negedge Clk);
        Rst        = rst;
        farmSensor = farm;
        walkButton = btn;
        model_edge(rst, farm, btn);
        sb_q.push_back(expected_vec(m_state, m_pend));
        @(posedge Clk);
        #1;
        got = {state, highwaySignal, farmSignal, walkSignal, walkPending};
        exp = sb_q.pop_front();
        check("sb_outputs", 32'(got), 32'(exp));
        conflict = (highwaySignal == 2'b11 && farmSignal == 2'b11) ||
                   (walkSignal == 2'b01 && (highwaySignal == 2'b11 || farmSignal == 2'b11));
        check("no_conflict", 32'(conflict), 32'd0);
    endtask

    task automatic expect_state(input string tag, input logic [3:0] s);
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic expect_pend(input string tag, input logic p);
        check(tag, 32'(walkPending), 32'(p));
    endtask

    initial begin
        Rst        = 1'b1;
        farmSensor = 1'b0;
        walkButton = 1'b0;

        // Idle: all-red after reset, then highway green rests
        cycle(1'b1, 1'b0, 1'b0);
        expect_state("idle_rst_state", 4'd7);
        check("idle_rst_hwy", 32'(highwaySignal), 32'h1);
        check("idle_rst_farm", 32'(farmSignal), 32'h1);
        check("idle_rst_walk", 32'(walkSignal), 32'h0);
        for (int k = 1; k <= 100; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (k == 1)   expect_state("idle_k1", 4'd0);
            if (k == 100) begin
                expect_state("idle_k100", 4'd0);
                check("idle_hwy_green", 32'(highwaySignal), 32'h3);
            end
        end

        // Farm held from cycle 5: served to the maximum green
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            cycle(1'b0, k >= 5, 1'b0);
            if (k == 30) expect_state("farm_k30", 4'd0);
            if (k == 31) expect_state("farm_k31", 4'd1);
            if (k == 34) expect_state("farm_k34", 4'd2);
            if (k == 35) expect_state("farm_k35", 4'd3);
            if (k == 49) expect_state("farm_k49", 4'd3);
            if (k == 50) expect_state("farm_k50", 4'd4);
            if (k == 53) expect_state("farm_k53", 4'd7);
            if (k == 54) expect_state("farm_k54", 4'd0);
        end

        // Farm leaves right after the decision: green ends at the minimum
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            cycle(1'b0, k <= 35, 1'b0);
            if (k == 37) expect_state("fmin_k37", 4'd3);
            if (k == 38) expect_state("fmin_k38", 4'd4);
        end

        // Single walk press
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            cycle(1'b0, 1'b0, k == 2);
            if (k == 1)  expect_pend("walk_pend_k1", 1'b0);
            if (k == 34) expect_pend("walk_pend_k34", 1'b1);
            if (k == 35) begin
                expect_state("walk_k35", 4'd5);
                expect_pend("walk_pend_k35", 1'b0);
                check("walk_lamp", 32'(walkSignal), 32'h1);
            end
            if (k == 44) expect_state("walk_k44", 4'd5);
            if (k == 45) begin
                expect_state("walk_k45", 4'd6);
                check("walk_flash", 32'(walkSignal), 32'h2);
            end
            if (k == 50) expect_state("walk_k50", 4'd7);
            if (k == 51) expect_state("walk_k51", 4'd0);
        end

        // Ties: farm first, then walk, then farm again
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 140; k++) begin
            cycle(1'b0, 1'b1, (k == 2) || (k == 100));
            if (k == 35)  expect_state("tie1_farm", 4'd3);
            if (k == 84)  expect_state("tie2_yellow", 4'd1);
            if (k == 88)  expect_state("tie2_walk", 4'd5);
            if (k == 104) expect_state("tie2_hwy", 4'd0);
            if (k == 138) expect_state("tie3_farm", 4'd3);
        end

        // Reset in the middle of farm green
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            cycle(k == 41, 1'b1, k == 2);
            if (k == 40) begin
                expect_state("rst_k40", 4'd3);
                expect_pend("rst_pend_k40", 1'b1);
            end
            if (k == 41) begin
                expect_state("rst_k41", 4'd7);
                expect_pend("rst_pend_k41", 1'b0);
                check("rst_farm_red", 32'(farmSignal), 32'h1);
            end
            if (k == 42) expect_state("rst_k42", 4'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
